// File: rtl/er_pkg.sv
// Shared Earthrise command-list definitions: opcodes, opcode field position, fetch state encoding.
// Used by the command fetcher and the draw engine decoder.
package er_pkg;

    localparam int ER_OP_W = 8;

    localparam logic [ER_OP_W-1:0] ER_OP_STOP = 8'h00;
    localparam logic [ER_OP_W-1:0] ER_OP_JUMP = 8'h01;

    typedef enum logic [1:0] {
        ER_IDLE  = 2'd0,
        ER_FETCH = 2'd1,
        ER_DRAIN = 2'd2,
        ER_DONE  = 2'd3
    } er_state_t;

    // Opcode occupies the top ER_OP_W bits of a command word.
    function automatic int er_op_lsb(input int word_w);
        return word_w - ER_OP_W;
    endfunction

endpackage

// File: rtl/er_fetch_fifo.sv
// Four-entry synchronous prefetch FIFO for the Earthrise command fetcher.
// The fetcher's read credit keeps it from overflowing, so no full flag is provided.
module er_fetch_fifo #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [2:0]   o_count
);

    logic [W-1:0] r_mem [4];
    logic [1:0]   r_wr;
    logic [1:0]   r_rd;
    logic [2:0]   r_cnt;
    logic         w_pop;

    assign w_pop = i_pop && (r_cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_wr  <= 2'd0;
            r_rd  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (i_push) r_wr <= r_wr + 2'd1;
            if (w_pop)  r_rd <= r_rd + 2'd1;
            r_cnt <= r_cnt + {2'b00, i_push} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end

    // Empty FIFO presents zeros so the stream outputs are clean after reset.
    assign o_valid = (r_cnt != 3'd0);
    assign o_dout  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/er_fetch.sv
// Earthrise command fetcher: walks the command list through the 2-cycle read port into a 4-deep FIFO.
// Optional feature macro: ERFETCH_JUMP_EN enables JUMP (opcode 8'h01) pointer redirects.
module er_fetch
    import er_pkg::*;
#(
    parameter int WORD  = 32,
    parameter int ADDRW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW-1:0] start_addr,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] addr_er,
    input  logic [WORD-1:0]  dout_er,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [WORD-1:0]  cmd_data,
    output logic [ADDRW-1:0] cmd_addr
);

    localparam int OP_LSB = er_op_lsb(WORD);
    localparam int FW     = WORD + ADDRW;

    er_state_t          r_state;
    er_state_t          w_state_nxt;
    logic               r_req_live;
    logic               r_s0_live;
    logic               r_s1_live;
    logic [ADDRW-1:0]   r_addr_er;
    logic [ADDRW-1:0]   r_s0_addr;
    logic [ADDRW-1:0]   r_s1_addr;
    logic [ADDRW-1:0]   r_ptr;
    logic [ADDRW-1:0]   w_iss_addr;
    logic               w_issue;
    logic               w_land;
    logic               w_is_stop;
    logic               w_is_jump;
    logic               w_kill;
    logic               w_push;
    logic               w_pop;
    logic               w_start;
    logic [ER_OP_W-1:0] w_op;
    logic [2:0]         w_fifo_cnt;
    logic [3:0]         w_outstanding;
    logic [FW-1:0]      w_fifo_dout;

    assign w_op      = dout_er[OP_LSB +: ER_OP_W];
    assign w_land    = r_s1_live && (r_state == ER_FETCH);
    assign w_is_stop = w_land && (w_op == ER_OP_STOP);
`ifdef ERFETCH_JUMP_EN
    assign w_is_jump = w_land && (w_op == ER_OP_JUMP);
`else
    assign w_is_jump = 1'b0;
`endif
    assign w_kill    = w_is_stop || w_is_jump;
    assign w_push    = w_land && !w_kill;
    assign w_pop     = cmd_valid && cmd_ready;
    assign w_start   = (r_state == ER_IDLE) && start;

    // Reads that will still hold a FIFO slot after this edge; the current pop frees one,
    // which is what lets one command per cycle flow with only four credits.
    assign w_outstanding = {1'b0, w_fifo_cnt} + {3'b000, w_push}
                         + (w_kill ? 4'd0 : ({3'b000, r_req_live} + {3'b000, r_s0_live}))
                         - {3'b000, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_iss_addr  = r_ptr;
        case (r_state)
            ER_IDLE: begin
                if (start) begin
                    w_state_nxt = ER_FETCH;
                    w_issue     = 1'b1;
                    w_iss_addr  = start_addr;
                end
            end
            ER_FETCH: begin
                if (w_is_stop) begin
                    w_state_nxt = ER_DRAIN;
                end else begin
                    w_issue = (w_outstanding < 4'd4);
`ifdef ERFETCH_JUMP_EN
                    if (w_is_jump) w_iss_addr = dout_er[ADDRW-1:0];
`endif
                end
            end
            ER_DRAIN: begin
                if (w_fifo_cnt == 3'd0) w_state_nxt = ER_DONE;
            end
            ER_DONE: begin
                w_state_nxt = ER_IDLE;
            end
            default: begin
                w_state_nxt = ER_IDLE;
            end
        endcase
    end

    // Read pipeline: addr_er (r_req_live) -> s0 -> s1, where s1 lines up with dout_er.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ER_IDLE;
            r_req_live <= 1'b0;
            r_s0_live  <= 1'b0;
            r_s1_live  <= 1'b0;
            r_addr_er  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_live <= w_issue;
            r_s0_live  <= r_req_live && !w_kill;
            r_s1_live  <= r_s0_live && !w_kill;
            if (w_issue) r_addr_er <= w_iss_addr;
        end
    end

    always_ff @(posedge clk) begin
        r_s0_addr <= r_addr_er;
        r_s1_addr <= r_s0_addr;
        if (w_issue) begin
            r_ptr <= w_iss_addr + ADDRW'(1);
        end
`ifdef ERFETCH_JUMP_EN
        else if (w_is_jump) begin
            r_ptr <= dout_er[ADDRW-1:0];
        end
`endif
    end

    er_fetch_fifo #(
        .W (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start),
        .i_push  (w_push),
        .i_din   ({dout_er, r_s1_addr}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (cmd_valid),
        .o_count (w_fifo_cnt)
    );

    assign busy     = (r_state == ER_FETCH) || (r_state == ER_DRAIN);
    assign done     = (r_state == ER_DONE);
    assign addr_er  = r_addr_er;
    assign cmd_data = w_fifo_dout[FW-1:ADDRW];
    assign cmd_addr = w_fifo_dout[ADDRW-1:0];

endmodule

// File: tb/tb_er_fetch.sv
// Self-checking bench for er_fetch: list memory model with 2-cycle latency plus a list-walking reference.
// Honours ERFETCH_JUMP_EN in its reference model when the macro is defined for the build.
module tb_er_fetch;

    localparam int WORD  = 32;
    localparam int ADDRW = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [ADDRW-1:0] start_addr;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] addr_er;
    logic [WORD-1:0]  dout_er;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WORD-1:0]  cmd_data;
    logic [ADDRW-1:0] cmd_addr;

    always #5 clk = ~clk;

    er_fetch #(.WORD(WORD), .ADDRW(ADDRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .addr_er    (addr_er),
        .dout_er    (dout_er),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_addr   (cmd_addr)
    );

    logic [WORD-1:0]  mem [512];
    logic [ADDRW-1:0] d1, d2;
    logic [40:0]      got_q[$];
    logic [40:0]      exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int first_valid, done_cyc, done_cnt, valid_cnt, busy_first, busy_last, stab_err, max_dist;
    logic [ADDRW-1:0] addr_c1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; then the list memory answers with the word addressed two cycles earlier.
    task automatic step();
        @(posedge clk);
        #1;
        dout_er = mem[d2];
        d2 = d1;
        d1 = addr_er;
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic [WORD-1:0] rand_cmd();
        return {8'($urandom_range(2, 255)), 24'($urandom)};
    endfunction

    // Walk the list as the draw engine should see it.
    function automatic void build_exp(input logic [ADDRW-1:0] sa);
        logic [ADDRW-1:0] p;
        logic [WORD-1:0]  w;
        exp_q.delete();
        p = sa;
        for (int n = 0; n < 1024; n++) begin
            w = mem[p];
            if (w[31:24] == 8'h00) break;
`ifdef ERFETCH_JUMP_EN
            if (w[31:24] == 8'h01) begin
                p = w[ADDRW-1:0];
                continue;
            end
`endif
            exp_q.push_back({w, p});
            p = p + 9'd1;
        end
    endfunction

    task automatic run(input string name, input logic [ADDRW-1:0] sa, input int mode, input int max_cyc);
        logic pv, pr;
        logic [WORD-1:0]  pd;
        logic [ADDRW-1:0] pa, last_pop, dd;
        build_exp(sa);
        got_q.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; valid_cnt = 0;
        busy_first = -1; busy_last = -1; stab_err = 0; max_dist = 0; addr_c1 = '0;
        last_pop = sa - 9'd1;
        pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
        start = 1'b1; start_addr = sa; cmd_ready = rdy(mode, 0);
        for (int c = 1; c <= max_cyc; c++) begin
            step();
            start = 1'b0;
            cmd_ready = rdy(mode, c);
            if (c == 1) addr_c1 = addr_er;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (pv && !pr && (!cmd_valid || cmd_data !== pd || cmd_addr !== pa)) stab_err++;
            if (cmd_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
            end
            if (cmd_valid && cmd_ready) begin
                got_q.push_back({cmd_data, cmd_addr});
                last_pop = cmd_addr;
            end
            dd = addr_er - last_pop;
            if (busy && int'(dd) > max_dist) max_dist = int'(dd);
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            pv = cmd_valid; pr = cmd_ready; pd = cmd_data; pa = cmd_addr;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
        end
        chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({name, "_idle_after"}, 64'(busy), 64'd0);
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({name, "_cmd"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        if (mode != 0) chk({name, "_stable"}, 64'(stab_err), 64'd0);
    endtask

    initial begin
        int dcount;
        logic [40:0] g0, g1;
        logic [ADDRW-1:0] sa;
        int len;

        for (int i = 0; i < 512; i++) mem[i] = rand_cmd();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; cmd_ready = 1'b0;
        dout_er = '0; d1 = '0; d2 = '0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_addr_er", 64'(addr_er), 64'd0);
        chk("rst_cmd_data", 64'(cmd_data), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // Two commands then STOP
        mem[9'h010] = 32'h0200_0001; mem[9'h011] = 32'h0200_0002; mem[9'h012] = 32'h0000_0000;
        run("basic", 9'h010, 0, 100);
        chk("basic_addr_c1", 64'(addr_c1), 64'h010);
        chk("basic_busy_first", 64'(busy_first), 64'd1);
        chk("basic_first_valid", 64'(first_valid), 64'd4);
        chk("basic_valid_cycles", 64'(valid_cnt), 64'd2);
        chk("basic_done_cyc", 64'(done_cyc), 64'd7);

        // STOP right at the start address
        mem[9'h030] = 32'h0000_0000;
        run("stop0", 9'h030, 0, 100);
        chk("stop0_valid_cycles", 64'(valid_cnt), 64'd0);
        chk("stop0_done_cyc", 64'(done_cyc), 64'd5);
        chk("stop0_busy_first", 64'(busy_first), 64'd1);
        chk("stop0_busy_last", 64'(busy_last), 64'd4);

        // 20 commands with a stalling consumer
        for (int k = 0; k < 20; k++) mem[9'h100 + 9'(k)] = rand_cmd();
        mem[9'h114] = 32'h0000_0000;
        run("stall20", 9'h100, 1, 400);
        chk("stall20_credit_ok", 64'(max_dist <= 4), 64'd1);

        // Address wrap
        mem[9'h1FE] = 32'h0A00_000A; mem[9'h1FF] = 32'h0B00_000B;
        mem[9'h000] = 32'h0C00_000C; mem[9'h001] = 32'h0000_0000;
        run("wrap", 9'h1FE, 0, 100);
        g0 = (got_q.size() > 2) ? got_q[2] : '1;
        chk("wrap_third_addr", 64'(g0[ADDRW-1:0]), 64'h000);

        // JUMP word
        mem[9'h040] = 32'h0100_0080; mem[9'h041] = 32'h0A00_00AA; mem[9'h042] = 32'h0000_0000;
        mem[9'h080] = 32'h0B00_00BB; mem[9'h081] = 32'h0000_0000;
        run("jump", 9'h040, 0, 100);
        g0 = (got_q.size() > 0) ? got_q[0] : '0;
        g1 = (got_q.size() > 1) ? got_q[1] : '0;
`ifdef ERFETCH_JUMP_EN
        chk("jump_n", 64'(got_q.size()), 64'd1);
        chk("jump_data", 64'(g0[40:9]), 64'h0B00_00BB);
        chk("jump_addr", 64'(g0[8:0]), 64'h080);
`else
        chk("jump_n", 64'(got_q.size()), 64'd2);
        chk("jump_data0", 64'(g0[40:9]), 64'h0100_0080);
        chk("jump_data1", 64'(g1[40:9]), 64'h0A00_00AA);
`endif

        // Reset mid-stream with three commands buffered
        for (int k = 0; k < 16; k++) mem[9'h150 + 9'(k)] = rand_cmd();
        start = 1'b1; start_addr = 9'h150; cmd_ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
        end
        chk("mr_valid_before", 64'(cmd_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valid", 64'(cmd_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        dcount = int'(done);
        for (int c = 0; c < 6; c++) begin
            step();
            if (done) dcount++;
        end
        chk("mr_no_done", 64'(dcount), 64'd0);
        run("mr_restart", 9'h010, 0, 100);
        chk("mr_restart_first_valid", 64'(first_valid), 64'd4);

        // Random lists with a random consumer
        for (int it = 0; it < 8; it++) begin
            sa = 9'($urandom_range(0, 511));
            len = $urandom_range(0, 12);
            for (int k = 0; k < len; k++) mem[sa + 9'(k)] = rand_cmd();
            mem[sa + 9'(len)] = 32'h0000_0000;
            run("rand", sa, 2, 400);
            chk("rand_credit_ok", 64'(max_dist <= 4), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/er_fetch.md
# er_fetch

Earthrise command fetcher: the read-side consumer of the Earthrise command list memory. On `start` it walks the list from a given word address, driving the list's Earthrise read port and absorbing its fixed two-cycle read latency. Commands go to the Earthrise draw engine over a valid/ready stream, buffered through a 4-entry prefetch FIFO. Fetch ends on a STOP command; when `ERFETCH_JUMP_EN` is defined, JUMP commands redirect the fetch pointer.

## Interface
Parameters:
- `WORD`, 32, command word width (bits); opcode is `[WORD-1:WORD-8]`
- `ADDRW`, 9, command list address width (bits)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `start`  in  1  begin fetching at `start_addr`; sampled only in IDLE
- `start_addr`  in  ADDRW  first command word address
- `busy`  out  1  high in FETCH and DRAIN
- `done`  out  1  one-cycle pulse when the list completes
- `addr_er`  out  ADDRW  registered list read address
- `dout_er`  in  WORD  list read data, valid 2 cycles after `addr_er`
- `cmd_valid`  out  1  command available
- `cmd_ready`  in  1  draw engine accepts command
- `cmd_data`  out  WORD  command word
- `cmd_addr`  out  ADDRW  list address the command was read from

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE→FETCH on `start`:
  - pointer ← `start_addr`.
  - FIFO and in-flight tracking cleared.
- Issue rule (FETCH only):
  - A read is issued in a cycle when outstanding < 4, where outstanding = in-flight reads (0–2) + FIFO occupancy.
  - Issue sets `addr_er` ← pointer; pointer ← pointer+1 mod 2^ADDRW.
  - Wrap from 2^ADDRW−1 to 0 is silent.
- In-flight tracking: a 2-stage shift register of {live, addr} mirrors the list read pipeline. A live entry landing with `dout_er` is classified by opcode:
  - STOP (8'h00): not enqueued. All other in-flight entries are killed. State→DRAIN.
  - JUMP (8'h01, macro defined): not enqueued. All other in-flight entries are killed. Pointer ← `dout_er[ADDRW-1:0]`. State stays FETCH. Issue resumes the next cycle.
  - Anything else: pushed into the FIFO as {data, addr}.
- FIFO output drives `cmd_valid`/`cmd_data`/`cmd_addr`. A pop happens on `cmd_valid && cmd_ready`.
- Stream rules:
  - `cmd_data` and `cmd_addr` are held stable while `cmd_valid && !cmd_ready`.
  - `cmd_valid` never drops without a pop.
- DRAIN: no issue. Commands already in the FIFO are still delivered. Landing entries are ignored (all are killed). DRAIN→DONE when the FIFO is empty.
- DONE: `done`=1 for one cycle, then →IDLE.
- `start` outside IDLE is ignored.
- Credit limit 4 guarantees the FIFO never overflows; no full flag is exported.

## Timing
- Reset values: `busy`=0, `done`=0, `cmd_valid`=0, `addr_er`=0, `cmd_data`=0, `cmd_addr`=0. State IDLE, FIFO empty, in-flight dead.
- Reset mid-operation returns to IDLE next cycle. No `done` pulse. Late read data is ignored.
- `start` sampled at cycle 0:
  - FETCH and `busy` from cycle 1.
  - `addr_er`=`start_addr` in cycle 1.
  - Data arrives on `dout_er` in cycle 3.
  - Earliest `cmd_valid` in cycle 4.
- Throughput: one command per cycle sustained with `cmd_ready` held high.
- STOP landing in cycle N with FIFO empty: DRAIN in N+1, `done` in N+2, IDLE in N+3.
- STOP and a pop in the same cycle are both honoured.
- JUMP landing in cycle N: `addr_er`=target in N+1. First post-jump command earliest at `cmd_valid` in N+4.

## Configuration
- `ERFETCH_JUMP_EN` defined: opcode 8'h01 is JUMP, handled as above.
- Not defined: 8'h01 is an ordinary command and is delivered on the stream. No redirect logic is synthesized.

## Structure
- Shared package `er_pkg` holds:
  - opcode constants `ER_OP_STOP`, `ER_OP_JUMP`
  - opcode field position
  - state encoding
- Also shared by the draw engine decoder.
- One sub-module: `er_fetch_fifo`, a synchronous 4-entry FIFO of {WORD+ADDRW} bits with push/pop/count.

## Test plan
- List at 0x010 = {0x02000001, 0x02000002, 0x00000000}, `cmd_ready`=1, start cycle 0 → `cmd_valid` cycles 4–5 with data 0x02000001/0x02000002 and `cmd_addr` 0x010/0x011; `done` at cycle 7; no third command.
- STOP at `start_addr` → no `cmd_valid`; `done` pulses exactly once at cycle 5; `busy` high in cycles 1–4.
- 20 ordinary commands then STOP, `cmd_ready` toggling 1-0-0-1 → all 20 delivered in order, no drops or duplicates; data held stable while stalled; `addr_er` never advances more than 4 beyond the last popped address.
- `start_addr`=2^ADDRW−2, list {cmdA, cmdB, cmdC, STOP} spanning the wrap → `cmd_addr` sequence 0x1FE, 0x1FF, 0x000.
- With macro: 0x040 = JUMP 0x080, 0x041 = cmdX, 0x080 = cmdY, 0x081 = STOP → only cmdY delivered, `cmd_addr`=0x080. Without macro: the JUMP word is delivered as data, then cmdX.
- `rst_n` low for one cycle mid-stream with FIFO holding 3 entries → next cycle `cmd_valid`=0, `busy`=0; no `done`; a new `start` fetches cleanly.
